// File: rtl/scan_sequencer_pkg.sv
// Shared definitions for the scan sequencer: channel count, index width
// and the FSM state encoding used by the top level.
package scan_sequencer_pkg;
  localparam int NUM_CH = 8;
  localparam int IDX_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_BLANK = 2'd2
  } state_t;
endpackage

// File: rtl/scan_sequencer_if.sv
// Control/status bundle between a scan controller and the scan sequencer.
//   start, stop, one_shot : scan control (master -> slave)
//   ch_mask               : channel enables, bit i = channel i
//   dwell                 : cycles sel_en stays high per channel (0 acts as 1)
//   sel, sel_en           : decoder index and enable (slave -> master)
//   busy, frame_done      : status (slave -> master)
interface scan_sequencer_if #(
  parameter int DWELL_W = 16
);
  import scan_sequencer_pkg::*;

  logic                start;
  logic                stop;
  logic                one_shot;
  logic [NUM_CH-1:0]   ch_mask;
  logic [DWELL_W-1:0]  dwell;
  logic [IDX_W-1:0]    sel;
  logic                sel_en;
  logic                busy;
  logic                frame_done;

  modport master (
    output start, stop, one_shot, ch_mask, dwell,
    input  sel, sel_en, busy, frame_done
  );

  modport slave (
    input  start, stop, one_shot, ch_mask, dwell,
    output sel, sel_en, busy, frame_done
  );
endinterface

// File: rtl/scan_next_ch.sv
// Rotating-priority search for the next enabled channel strictly above cur,
// wrapping around. With cur = 7 the result is the lowest set bit.
//   cur     : current channel index
//   mask    : channel enables
//   nxt     : next enabled channel (cur when mask is empty)
//   wrapped : nxt is not above cur, i.e. the frame has wrapped
//   none    : mask is empty
module scan_next_ch
  import scan_sequencer_pkg::*;
(
  input  logic [IDX_W-1:0]  cur,
  input  logic [NUM_CH-1:0] mask,
  output logic [IDX_W-1:0]  nxt,
  output logic              wrapped,
  output logic              none
);
  logic [IDX_W-1:0] idx;

  // Walk from the farthest offset to the nearest so the nearest set bit wins.
  // Offset NUM_CH truncates to cur itself, covering the single-channel case.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    nxt = cur;
    idx = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = cur + IDX_W'(i);
      if (mask[idx]) nxt = idx;
    end
  end

  assign none    = (mask == '0);
  assign wrapped = (nxt <= cur);
endmodule

// File: rtl/scan_sequencer.sv
// Timed channel scanner feeding a 3-to-8 decoder. Dwells on each enabled
// channel for a programmable number of cycles, blanks sel_en between
// channels, and either loops or stops after one frame.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of scan_sequencer_if (control in, sel/status out)
// All outputs come straight from registers.
module scan_sequencer
  import scan_sequencer_pkg::*;
#(
  parameter int DWELL_W      = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  scan_sequencer_if.slave    bus
);
  localparam int  BW        = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam bit  HAS_BLANK = (BLANK_CYCLES > 0);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]   pend_q, pend_d;       // channel to show after blanking
  logic               sel_en_q, sel_en_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               one_shot_q, one_shot_d;
  logic [DWELL_W-1:0] dwell_lat_q, dwell_lat_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [BW-1:0]      blank_cnt_q, blank_cnt_d;

  logic [IDX_W-1:0]   search_cur;
  logic [IDX_W-1:0]   nxt;
  logic               wrapped;
  logic               none;

  function automatic logic [DWELL_W-1:0] eff_dwell(input logic [DWELL_W-1:0] d);
    return (d == '0) ? DWELL_W'(1) : d;
  endfunction

  // In IDLE, searching above the top channel yields the lowest enabled one.
  assign search_cur = (state_q == ST_IDLE) ? IDX_W'(NUM_CH - 1) : sel_q;

  scan_next_ch u_next (
    .cur     (search_cur),
    .mask    (bus.ch_mask),
    .nxt     (nxt),
    .wrapped (wrapped),
    .none    (none)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    pend_d       = pend_q;
    sel_en_d     = sel_en_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    one_shot_d   = one_shot_q;
    dwell_lat_d  = dwell_lat_q;
    dwell_cnt_d  = dwell_cnt_q;
    blank_cnt_d  = blank_cnt_q;

    if (bus.stop) begin
      state_d  = ST_IDLE;
      sel_en_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start && !none) begin
            state_d     = ST_DWELL;
            sel_d       = nxt;
            sel_en_d    = 1'b1;
            busy_d      = 1'b1;
            one_shot_d  = bus.one_shot;
            dwell_lat_d = eff_dwell(bus.dwell);
            dwell_cnt_d = eff_dwell(bus.dwell) - DWELL_W'(1);
          end
        end

        ST_DWELL: begin
          if (dwell_cnt_q != '0) begin
            dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
          end else if (none) begin
            state_d  = ST_IDLE;
            sel_en_d = 1'b0;
            busy_d   = 1'b0;
          end else begin
            frame_done_d = wrapped;
            // A new dwell only takes effect at a frame boundary.
            if (wrapped) dwell_lat_d = eff_dwell(bus.dwell);
            if (wrapped && one_shot_q) begin
              state_d  = ST_IDLE;
              sel_en_d = 1'b0;
              busy_d   = 1'b0;
            end else if (HAS_BLANK) begin
              state_d     = ST_BLANK;
              sel_en_d    = 1'b0;
              pend_d      = nxt;
              blank_cnt_d = BW'(BLANK_CYCLES - 1);
            end else begin
              sel_d       = nxt;
              dwell_cnt_d = dwell_lat_d - DWELL_W'(1);
            end
          end
        end

        ST_BLANK: begin
          if (blank_cnt_q != '0) begin
            blank_cnt_d = blank_cnt_q - BW'(1);
          end else begin
            state_d     = ST_DWELL;
            sel_d       = pend_q;
            sel_en_d    = 1'b1;
            dwell_cnt_d = dwell_lat_q - DWELL_W'(1);
          end
        end

        default: begin
          state_d  = ST_IDLE;
          sel_en_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      pend_q       <= '0;
      sel_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      one_shot_q   <= 1'b0;
      dwell_lat_q  <= '0;
      dwell_cnt_q  <= '0;
      blank_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      pend_q       <= pend_d;
      sel_en_q     <= sel_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      one_shot_q   <= one_shot_d;
      dwell_lat_q  <= dwell_lat_d;
      dwell_cnt_q  <= dwell_cnt_d;
      blank_cnt_q  <= blank_cnt_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.sel_en     = sel_en_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
endmodule
